booth_pe_sequencer: RTL and testbench
=====================================

# booth_pe_sequencer

Per-processing-element sequencer for the systolic array. It accepts one signed operand pair per MAC from the west/north neighbours and forwards the pair east/south. It launches the Booth multiplier (controller plus datapath) with a start pulse, waits for its done, and accumulates the signed product. Every K_LEN products it emits one dot-product result. It sits directly upstream of the Booth multiplier, drives its start, and consumes its done and product.

## Interface
- DATA_W, 8: operand width; signed two's complement.
- ACC_W, 20: accumulator and result width; must be ≥ 2*DATA_W.
- K_LEN, 4: products per result; range 1..255.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- a_in, input, DATA_W: operand from west neighbour.
- b_in, input, DATA_W: operand from north neighbour.
- in_valid, input, 1: operand pair present.
- in_ready, output, 1: high only in IDLE; a transfer occurs when in_valid && in_ready at an edge.
- a_out, output, DATA_W: registered copy of accepted a_in, to the east.
- b_out, output, DATA_W: registered copy of accepted b_in, to the south.
- fwd_valid, output, 1: one-cycle pulse, the cycle after acceptance.
- mul_start, output, 1: start pulse to the Booth controller.
- mul_mcand, output, DATA_W: multiplicand to the Booth datapath.
- mul_mplier, output, DATA_W: multiplier to the Booth datapath.
- mul_done, input, 1: Booth controller done.
- mul_product, input, 2*DATA_W: signed product, valid while mul_done=1.
- acc_clr, input, 1: synchronous accumulator/count clear.
- result, output, ACC_W: completed dot product.
- result_valid, output, 1: one-cycle pulse.

## Operation
- States: IDLE, LAUNCH, WAIT.
- IDLE: in_ready=1. On transfer, capture a_in→mul_mcand and a_out, and b_in→mul_mplier and b_out. Set fwd_valid=1 for the next cycle. Go to LAUNCH.
- LAUNCH: mul_start=1 for exactly this one cycle; go to WAIT.
- WAIT: mul_start=0. Hold mul_mcand and mul_mplier stable; the multiplier loads them several cycles after start.
  - On an edge with mul_done=1: acc ← acc + sext(mul_product), cnt ← cnt+1, go to IDLE.
  - Otherwise remain in WAIT indefinitely.
- Result completion: if the increment makes cnt = K_LEN, then result ← the new sum, result_valid=1 for one cycle, and acc ← 0, cnt ← 0 instead.
- acc_clr, not coincident with an accumulate: acc ← 0, cnt ← 0.
- acc_clr coincident with an accumulate: clear first, then add. acc ← sext(mul_product), cnt ← 1; if K_LEN=1, result_valid fires with sext(mul_product).
- mul_done while in IDLE or LAUNCH: ignored. This covers a stale done after reset.
- in_valid in LAUNCH or WAIT: not accepted (in_ready=0); the upstream holds its data.
- Arithmetic: signed, ACC_W bits. Overflow behaviour is set under Configuration.

## Timing
- Reset values: state=IDLE, in_ready=1, and all other outputs 0. acc=0 and cnt=0.
- Reset mid-operation: everything returns to reset values immediately; any in-flight product is discarded.
- Acceptance at edge N:
  - fwd_valid, a_out and b_out are valid in cycle N+1.
  - mul_start is high in cycle N+1, and in_ready is low from N+1.
- mul_done sampled high at edge M: acc, result and result_valid update at M; in_ready is high in cycle M+1.
- Minimum throughput: one pair per (3 + multiplier latency) cycles.
- fwd_valid has no backpressure; downstream PEs always accept.

## Configuration
- PE_SATURATE_EN defined: an accumulate that overflows clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and the clamped value is also what result reports.
- PE_SATURATE_EN undefined: two's-complement wrap-around modulo 2^ACC_W.

## Test plan
- Single MAC: a=3, b=5, with the bench model returning done and product 15 six cycles after mul_start. Expect a one-cycle mul_start, mcand=3, mplier=5, fwd_valid with a_out=3/b_out=5 in the cycle after acceptance, and internal acc=15.
- Dot product, K_LEN=4: pairs (3,5), (-2,7), (10,10), (-1,-1). Expect a single result_valid pulse with result=102, and the next pair starting from acc=0.
- Overflow, ACC_W=16, K_LEN=4: three products of 127×127=16129.
  - With PE_SATURATE_EN: result path clamps to 32767.
  - Without it: the third sum wraps to -17149.
  - Check via a fourth product 0: result = 32767 or -17149 respectively.
- Backpressure: hold in_valid=1 with new data during WAIT. Expect in_ready=0 and no capture; the data is accepted on the first IDLE cycle after mul_done.
- Reset in WAIT: assert rst mid-wait. Expect all outputs 0 immediately. A later mul_done=1 with product 99 after reset release must leave acc=0 and raise no result_valid.
- acc_clr coincident with mul_done (product 20, prior acc=50, cnt=2). Expect acc=20, cnt=1, and no result_valid.

Source files
------------

// File: rtl/booth_pe_sequencer_if.sv
// Operand handshake, forward path, Booth multiplier hookup and result bundle
// for one systolic-array PE sequencer.
interface booth_pe_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic [DATA_W-1:0]   a_in;
    logic [DATA_W-1:0]   b_in;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   a_out;
    logic [DATA_W-1:0]   b_out;
    logic                fwd_valid;
    logic                mul_start;
    logic [DATA_W-1:0]   mul_mcand;
    logic [DATA_W-1:0]   mul_mplier;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic                acc_clr;
    logic [ACC_W-1:0]    result;
    logic                result_valid;

    modport slave (
        input  a_in, b_in, in_valid, mul_done, mul_product, acc_clr,
        output in_ready, a_out, b_out, fwd_valid, mul_start, mul_mcand, mul_mplier,
               result, result_valid
    );

    modport master (
        output a_in, b_in, in_valid, mul_done, mul_product, acc_clr,
        input  in_ready, a_out, b_out, fwd_valid, mul_start, mul_mcand, mul_mplier,
               result, result_valid
    );
endinterface

// File: rtl/booth_pe_sequencer.sv
// PE sequencer: accepts operand pairs, launches the Booth multiplier and accumulates
// K_LEN signed products per result. Define PE_SATURATE_EN to clamp on overflow.
//
// state  | meaning
// IDLE   | ready for an operand pair
// LAUNCH | one-cycle start pulse to the multiplier
// WAIT   | operands held stable until the multiplier reports done
module booth_pe_sequencer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int K_LEN  = 4
) (
    input logic               clk,
    input logic               rst,
    booth_pe_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    localparam logic [7:0] K_TC = 8'(K_LEN);

    state_t state_q, state_d;

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, mc_q, mc_d, mp_q, mp_d;
    logic              fwd_q, fwd_d, rv_q, rv_d;
    logic [ACC_W-1:0]  acc_q, acc_d, res_q, res_d;
    logic [7:0]        cnt_q, cnt_d;

    logic                    accept, accum;
    logic [ACC_W-1:0]        acc_base;
    logic [7:0]              cnt_base, cnt_inc;
    logic signed [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0]        sum;
`ifdef PE_SATURATE_EN
    logic [ACC_W:0]          sum_wide;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        accum   = 1'b0;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                accept  = 1'b1;
                state_d = LAUNCH;
            end
            LAUNCH: state_d = WAIT;
            WAIT: if (bus.mul_done) begin
                accum   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign prod_ext = ACC_W'($signed(bus.mul_product));

    // A clear coincident with an accumulate wipes the old sum before the add.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        fwd_d    = accept;
        rv_d     = 1'b0;
        res_d    = res_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        acc_base = bus.acc_clr ? '0 : acc_q;
        cnt_base = bus.acc_clr ? '0 : cnt_q;
        cnt_inc  = cnt_base + 8'd1;
`ifdef PE_SATURATE_EN
        sum_wide = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
            sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum = sum_wide[ACC_W-1:0];
`else
        sum = acc_base + prod_ext;
`endif
        if (accept) begin
            a_d  = bus.a_in;
            b_d  = bus.b_in;
            mc_d = bus.a_in;
            mp_d = bus.b_in;
        end
        if (accum) begin
            if (cnt_inc == K_TC) begin
                res_d = sum;
                rv_d  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
        end else if (bus.acc_clr) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            mc_q  <= '0;
            mp_q  <= '0;
            fwd_q <= 1'b0;
            rv_q  <= 1'b0;
            res_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            mc_q  <= mc_d;
            mp_q  <= mp_d;
            fwd_q <= fwd_d;
            rv_q  <= rv_d;
            res_q <= res_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.mul_start    = (state_q == LAUNCH);
    assign bus.a_out        = a_q;
    assign bus.b_out        = b_q;
    assign bus.fwd_valid    = fwd_q;
    assign bus.mul_mcand    = mc_q;
    assign bus.mul_mplier   = mp_q;
    assign bus.result       = res_q;
    assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_booth_pe_sequencer.sv
// Self-checking bench for booth_pe_sequencer: transaction-level model plus
// directed MAC, dot-product, overflow, backpressure, reset and clear scenarios.
module tb_booth_pe_sequencer;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int K_LEN  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    booth_pe_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
    booth_pe_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .K_LEN(K_LEN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint fit(input longint s);
        longint r;
`ifdef PE_SATURATE_EN
        r = s;
        if (s > (longint'(1) << (ACC_W-1)) - 1) r = (longint'(1) << (ACC_W-1)) - 1;
        if (s < -(longint'(1) << (ACC_W-1)))    r = -(longint'(1) << (ACC_W-1));
`else
        r = s & ((longint'(1) << ACC_W) - 1);
        if (r >= (longint'(1) << (ACC_W-1))) r = r - (longint'(1) << ACC_W);
`endif
        return r;
    endfunction

    // Model: pending-launch / waiting flags and a signed integer sum.
    bit     m_ready, m_start, m_fwd, m_wait, m_rv;
    longint m_a, m_b, m_mc, m_mp, m_acc, m_res;
    int     m_cnt;
    bit     ev_acc, ev_take;
    longint ev_base, ev_sum;
    int     ev_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 1; m_start = 0; m_fwd = 0; m_wait = 0; m_rv = 0;
            m_a = 0; m_b = 0; m_mc = 0; m_mp = 0; m_acc = 0; m_res = 0; m_cnt = 0;
        end else begin
            ev_acc  = m_wait && bus.mul_done;
            ev_take = m_ready && bus.in_valid;
            m_rv    = 0;
            if (ev_acc) begin
                ev_base = bus.acc_clr ? 0 : m_acc;
                ev_cnt  = (bus.acc_clr ? 0 : m_cnt) + 1;
                ev_sum  = fit(ev_base + longint'($signed(bus.mul_product)));
                if (ev_cnt == K_LEN) begin
                    m_res = ev_sum; m_rv = 1; m_acc = 0; m_cnt = 0;
                end else begin
                    m_acc = ev_sum; m_cnt = ev_cnt;
                end
            end else if (bus.acc_clr) begin
                m_acc = 0; m_cnt = 0;
            end
            if (ev_take) begin
                m_a  = longint'($signed(bus.a_in));
                m_b  = longint'($signed(bus.b_in));
                m_mc = m_a;
                m_mp = m_b;
            end
            m_fwd   = ev_take;
            m_wait  = m_start || (m_wait && !bus.mul_done);
            m_start = ev_take;
            m_ready = (m_ready && !ev_take) || ev_acc;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("in_ready",     bus.in_ready,               m_ready);
            check("mul_start",    bus.mul_start,              m_start);
            check("fwd_valid",    bus.fwd_valid,              m_fwd);
            check("a_out",        $signed(bus.a_out),         m_a);
            check("b_out",        $signed(bus.b_out),         m_b);
            check("mul_mcand",    $signed(bus.mul_mcand),     m_mc);
            check("mul_mplier",   $signed(bus.mul_mplier),    m_mp);
            check("result_valid", bus.result_valid,           m_rv);
            check("result",       $signed(bus.result),        m_res);
            check("acc",          $signed(dut.acc_q),         m_acc);
            check("cnt",          dut.cnt_q,                  m_cnt);
        end
    end

    task automatic send_pair(input int a, input int b);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_in     = DATA_W'(a);
        bus.b_in     = DATA_W'(b);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_mul(input int lat, input int prod, input bit clr);
        repeat (lat) @(negedge clk);
        bus.mul_done    = 1'b1;
        bus.mul_product = (2*DATA_W)'(prod);
        bus.acc_clr     = clr;
        @(negedge clk);
        bus.mul_done    = 1'b0;
        bus.acc_clr     = 1'b0;
    endtask

    task automatic mac(input int a, input int b);
        send_pair(a, b);
        finish_mul(3, a * b, 1'b0);
    endtask

`ifdef PE_SATURATE_EN
    localparam longint OVF_EXP = 32767;
`else
    localparam longint OVF_EXP = -17149;
`endif

    initial begin
        bus.a_in = '0; bus.b_in = '0; bus.in_valid = 1'b0;
        bus.mul_done = 1'b0; bus.mul_product = '0; bus.acc_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_mul_start", bus.mul_start, 0);
        check("rst_fwd",       bus.fwd_valid, 0);
        check("rst_result",    bus.result, 0);
        check("rst_acc",       dut.acc_q, 0);

        // single MAC 3*5 with a six-cycle multiplier
        send_pair(3, 5);
        check("mac_start",  bus.mul_start, 1);
        check("mac_fwd",    bus.fwd_valid, 1);
        check("mac_a_out",  bus.a_out, 3);
        check("mac_b_out",  bus.b_out, 5);
        check("mac_mcand",  bus.mul_mcand, 3);
        check("mac_mplier", bus.mul_mplier, 5);
        check("mac_ready",  bus.in_ready, 0);
        @(negedge clk);
        check("mac_start_once", bus.mul_start, 0);
        check("mac_fwd_once",   bus.fwd_valid, 0);
        finish_mul(5, 15, 1'b0);
        check("mac_acc",       $signed(dut.acc_q), 15);
        check("mac_model_acc", m_acc, 15);
        check("mac_ready_back", bus.in_ready, 1);

        // dot product over K_LEN=4
        mac(-2, 7);
        mac(10, 10);
        mac(-1, -1);
        check("dot_rv",     bus.result_valid, 1);
        check("dot_result", $signed(bus.result), 102);
        check("dot_model",  m_res, 102);
        check("dot_acc0",   dut.acc_q, 0);
        @(negedge clk);
        check("dot_rv_pulse", bus.result_valid, 0);

        // overflow on a 16-bit accumulator
        mac(127, 127);
        mac(127, 127);
        mac(127, 127);
        check("ovf_acc", $signed(dut.acc_q), OVF_EXP);
        mac(0, 0);
        check("ovf_rv",     bus.result_valid, 1);
        check("ovf_result", $signed(bus.result), OVF_EXP);
        check("ovf_model",  m_res, OVF_EXP);

        // backpressure: new data presented during WAIT is held off
        send_pair(1, 1);
        bus.in_valid = 1'b1; bus.a_in = 8'd7; bus.b_in = 8'd2;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", bus.in_ready, 0);
            check("bp_a_hold",    bus.a_out, 1);
            check("bp_mc_hold",   bus.mul_mcand, 1);
        end
        bus.mul_done = 1'b1; bus.mul_product = 16'd1;
        @(negedge clk);
        bus.mul_done = 1'b0;
        check("bp_ready_back", bus.in_ready, 1);
        check("bp_acc",        dut.acc_q, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_fwd",   bus.fwd_valid, 1);
        check("bp_a_out", bus.a_out, 7);
        check("bp_b_out", bus.b_out, 2);
        check("bp_start", bus.mul_start, 1);
        finish_mul(3, 14, 1'b0);
        check("bp_acc2", dut.acc_q, 15);

        // standalone clear, then clear coincident with done
        @(negedge clk);
        bus.acc_clr = 1'b1;
        @(negedge clk);
        bus.acc_clr = 1'b0;
        check("clr_acc", dut.acc_q, 0);
        check("clr_cnt", dut.cnt_q, 0);
        mac(5, 5);
        mac(5, 5);
        check("pre_acc", dut.acc_q, 50);
        check("pre_cnt", dut.cnt_q, 2);
        send_pair(4, 5);
        finish_mul(4, 20, 1'b1);
        check("clrdone_acc", dut.acc_q, 20);
        check("clrdone_cnt", dut.cnt_q, 1);
        check("clrdone_rv",  bus.result_valid, 0);

        // reset while waiting for the multiplier
        send_pair(9, 9);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw_ready",  bus.in_ready, 1);
        check("rstw_start",  bus.mul_start, 0);
        check("rstw_fwd",    bus.fwd_valid, 0);
        check("rstw_a_out",  bus.a_out, 0);
        check("rstw_mcand",  bus.mul_mcand, 0);
        check("rstw_result", bus.result, 0);
        check("rstw_acc",    dut.acc_q, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.mul_done = 1'b1; bus.mul_product = 16'd99;
        @(negedge clk);
        bus.mul_done = 1'b0;
        check("stale_acc", dut.acc_q, 0);
        check("stale_rv",  bus.result_valid, 0);
        check("stale_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
